// File: rtl/sr_arbiter_if.sv
// Write-port bundle between the two SR requesters, the arbiter and the
// special-register block.
interface sr_arbiter_if #(
  parameter int SEL_W  = 16,
  parameter int DATA_W = 16
);
  logic              core_req;
  logic [SEL_W-1:0]  core_sel;
  logic [DATA_W-1:0] core_data;
  logic              core_ack;
  logic              dbg_req;
  logic [SEL_W-1:0]  dbg_sel;
  logic [DATA_W-1:0] dbg_data;
  logic              dbg_ack;
  logic              sr_ie;
  logic [SEL_W-1:0]  sr_sel;
  logic [DATA_W-1:0] sr_in;
  logic              sr_err;
  logic              grant_dbg;

  modport master (
    output core_req, core_sel, core_data, dbg_req, dbg_sel, dbg_data,
    input  core_ack, dbg_ack, sr_ie, sr_sel, sr_in, sr_err, grant_dbg
  );

  modport slave (
    input  core_req, core_sel, core_data, dbg_req, dbg_sel, dbg_data,
    output core_ack, dbg_ack, sr_ie, sr_sel, sr_in, sr_err, grant_dbg
  );
endinterface

// File: rtl/sr_arbiter.sv
// Arbitrates core and debug writes onto the special-register write port:
// IDLE -> WRITE (strobe) -> ACK, debug priority bounded by a starvation count.
module sr_arbiter #(
  parameter int SEL_W      = 16,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input logic        clk,
  input logic        rst_n,
  sr_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              valid_q, valid_d;
  logic              grant_dbg_q, grant_dbg_d;
  logic              sr_ie_q, sr_ie_d;
  logic [SEL_W-1:0]  sr_sel_q, sr_sel_d;
  logic [DATA_W-1:0] sr_in_q, sr_in_d;
  logic              core_ack_q, core_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              sr_err_q, sr_err_d;

  logic              pick_dbg;
  logic [SEL_W-1:0]  win_sel;
  logic [DATA_W-1:0] win_data;

  function automatic logic is_onehot(input logic [SEL_W-1:0] s);
    return (s != '0) && ((s & (s - SEL_W'(1))) == '0);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(STARVE_MAX)) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    valid_d     = valid_q;
    grant_dbg_d = 1'b0;
    sr_ie_d     = 1'b0;
    sr_sel_d    = '0;
    sr_in_d     = '0;
    core_ack_d  = 1'b0;
    dbg_ack_d   = 1'b0;
    sr_err_d    = 1'b0;

    // Debug wins ties unless the core has waited through STARVE_MAX debug grants.
    pick_dbg = bus.dbg_req && !(bus.core_req && (starve_q == CNT_W'(STARVE_MAX)));
    win_sel  = pick_dbg ? bus.dbg_sel  : bus.core_sel;
    win_data = pick_dbg ? bus.dbg_data : bus.core_data;

    unique case (state_q)
      IDLE: begin
        if (bus.core_req || bus.dbg_req) begin
          valid_d     = is_onehot(win_sel);
          grant_dbg_d = pick_dbg;
          sr_ie_d     = valid_d;
          sr_sel_d    = valid_d ? win_sel  : '0;
          sr_in_d     = valid_d ? win_data : '0;
          if (!pick_dbg)         starve_d = '0;
          else if (bus.core_req) starve_d = sat_inc(starve_q);
          state_d     = WRITE;
        end
      end
      WRITE: begin
        grant_dbg_d = grant_dbg_q;
        core_ack_d  = !grant_dbg_q;
        dbg_ack_d   = grant_dbg_q;
        sr_err_d    = !valid_q;
        state_d     = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      valid_q     <= 1'b0;
      grant_dbg_q <= 1'b0;
      sr_ie_q     <= 1'b0;
      sr_sel_q    <= '0;
      sr_in_q     <= '0;
      core_ack_q  <= 1'b0;
      dbg_ack_q   <= 1'b0;
      sr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      valid_q     <= valid_d;
      grant_dbg_q <= grant_dbg_d;
      sr_ie_q     <= sr_ie_d;
      sr_sel_q    <= sr_sel_d;
      sr_in_q     <= sr_in_d;
      core_ack_q  <= core_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      sr_err_q    <= sr_err_d;
    end
  end

  assign bus.sr_ie     = sr_ie_q;
  assign bus.sr_sel    = sr_sel_q;
  assign bus.sr_in     = sr_in_q;
  assign bus.core_ack  = core_ack_q;
  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.sr_err    = sr_err_q;
  assign bus.grant_dbg = grant_dbg_q;
endmodule

// File: tb/tb_sr_arbiter.sv
// Scoreboard bench for sr_arbiter: requester drivers feed item queues, a
// monitor pops expected transactions on every ack and checks the write cycle.
module tb_sr_arbiter;
  localparam int SEL_W      = 16;
  localparam int DATA_W     = 16;
  localparam int STARVE_MAX = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_arbiter_if #(.SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  sr_arbiter #(.SEL_W(SEL_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] sel;
    logic [15:0] data;
  } req_t;

  typedef struct {
    bit          dbg;
    bit          valid;
    logic [15:0] sel;
    logic [15:0] data;
    int          starve;
  } exp_t;

  req_t core_items[$];
  req_t dbg_items[$];
  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit dbg, input bit valid, input logic [15:0] sel,
                          input logic [15:0] data, input int starve);
    exp_t e;
    e.dbg = dbg; e.valid = valid; e.sel = sel; e.data = data; e.starve = starve;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name, input int max_cyc);
    int n = 0;
    while ((exp_q.size() != 0 || core_items.size() != 0 || dbg_items.size() != 0) && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  // Core requester: holds req through its ack, then re-asserts with the next item or drops.
  initial begin : core_drv
    bit   ack_seen;
    req_t it;
    ack_seen = 1'b0;
    bus.core_req = 1'b0; bus.core_sel = '0; bus.core_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack_seen) begin
          ack_seen = 1'b0;
          if (core_items.size() != 0) begin
            it = core_items.pop_front();
            bus.core_sel = it.sel; bus.core_data = it.data;
          end else begin
            bus.core_req = 1'b0;
          end
        end else if (bus.core_req && bus.core_ack) begin
          ack_seen = 1'b1;
        end else if (!bus.core_req && core_items.size() != 0) begin
          it = core_items.pop_front();
          bus.core_sel = it.sel; bus.core_data = it.data; bus.core_req = 1'b1;
        end
      end
    end
  end

  initial begin : dbg_drv
    bit   ack_seen;
    req_t it;
    ack_seen = 1'b0;
    bus.dbg_req = 1'b0; bus.dbg_sel = '0; bus.dbg_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (ack_seen) begin
          ack_seen = 1'b0;
          if (dbg_items.size() != 0) begin
            it = dbg_items.pop_front();
            bus.dbg_sel = it.sel; bus.dbg_data = it.data;
          end else begin
            bus.dbg_req = 1'b0;
          end
        end else if (bus.dbg_req && bus.dbg_ack) begin
          ack_seen = 1'b1;
        end else if (!bus.dbg_req && dbg_items.size() != 0) begin
          it = dbg_items.pop_front();
          bus.dbg_sel = it.sel; bus.dbg_data = it.data; bus.dbg_req = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    exp_t        e;
    logic        p_ie, p_gd;
    logic [15:0] p_sel, p_in;
    bit          after_ack;
    p_ie = 1'b0; p_gd = 1'b0; p_sel = '0; p_in = '0; after_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_ie = 1'b0; p_gd = 1'b0; p_sel = '0; p_in = '0; after_ack = 1'b0;
      end else begin
        if (after_ack)
          chk("idle_outputs", {bus.sr_ie, bus.sr_sel, bus.sr_in, bus.grant_dbg,
                               bus.core_ack, bus.dbg_ack, bus.sr_err}, 64'd0);
        after_ack = 1'b0;
        if (bus.core_ack || bus.dbg_ack) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL unexpected_ack: got core_ack=%0b dbg_ack=%0b, expected no ack",
                     bus.core_ack, bus.dbg_ack);
          end else begin
            e = exp_q.pop_front();
            chk("ack_owner", {bus.dbg_ack, bus.core_ack}, e.dbg ? 2'b10 : 2'b01);
            chk("ack_grant_dbg", bus.grant_dbg, e.dbg);
            chk("write_grant_dbg", p_gd, e.dbg);
            chk("write_strobe", p_ie, e.valid);
            chk("write_sel", p_sel, e.valid ? e.sel : 16'h0);
            chk("write_data", p_in, e.valid ? e.data : 16'h0);
            chk("ack_err", bus.sr_err, !e.valid);
            chk("ack_no_strobe", bus.sr_ie, 1'b0);
            chk("starve_cnt", dut.starve_q, 64'(e.starve));
          end
          after_ack = 1'b1;
        end else if (bus.sr_err) begin
          n_cmp++; n_fail++;
          $display("FAIL err_without_ack: got sr_err=1, expected 0");
        end
        p_ie = bus.sr_ie; p_gd = bus.grant_dbg; p_sel = bus.sr_sel; p_in = bus.sr_in;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int ci, di, sv;
    int t[$];
    bit seen;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", {bus.core_ack, bus.dbg_ack, bus.sr_ie, bus.sr_sel, bus.sr_in,
                          bus.sr_err, bus.grant_dbg}, 64'd0);
    chk("reset_starve", dut.starve_q, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // Core alone, with exact strobe/ack latency.
    @(negedge clk); #1;
    push_exp(1'b0, 1'b1, 16'h0002, 16'h0001, 0);
    core_items.push_back('{16'h0002, 16'h0001});
    @(negedge clk);
    @(negedge clk); #1;
    chk("core_strobe", {bus.sr_ie, bus.sr_sel, bus.sr_in}, {1'b1, 16'h0002, 16'h0001});
    @(negedge clk); #1;
    chk("core_ack_pulse", {bus.core_ack, bus.dbg_ack, bus.sr_err}, 3'b100);
    drain("core_alone", 20);

    // Contention: D,D,D,D,C,D,D,D,D,C with starve 1,2,3,4,0,1,2,3,4,0.
    #1;
    ci = 0; di = 0;
    for (int j = 0; j < 10; j++) begin
      if (j == 4 || j == 9) begin
        push_exp(1'b0, 1'b1, 16'(16'h0010 << ci), 16'(16'hC000 + ci), 0);
        ci++;
      end else begin
        sv = (j < 4) ? j + 1 : j - 4;
        push_exp(1'b1, 1'b1, 16'(16'h0001 << di), 16'(16'hD000 + di), sv);
        di++;
      end
    end
    for (int i = 0; i < 8; i++) dbg_items.push_back('{16'(16'h0001 << i), 16'(16'hD000 + i)});
    for (int i = 0; i < 2; i++) core_items.push_back('{16'(16'h0010 << i), 16'(16'hC000 + i)});
    drain("contention", 100);

    // Invalid selects from debug: no strobe, err with ack.
    #1;
    push_exp(1'b1, 1'b0, 16'h0000, 16'h1234, 0);
    push_exp(1'b1, 1'b0, 16'h0003, 16'h5678, 0);
    dbg_items.push_back('{16'h0000, 16'h1234});
    dbg_items.push_back('{16'h0003, 16'h5678});
    drain("invalid_sel", 30);

    // Back-to-back: core keeps req high through its ack.
    #1;
    push_exp(1'b0, 1'b1, 16'h8000, 16'hAAAA, 0);
    push_exp(1'b0, 1'b1, 16'h4000, 16'h5555, 0);
    core_items.push_back('{16'h8000, 16'hAAAA});
    core_items.push_back('{16'h4000, 16'h5555});
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.sr_ie) t.push_back(cyc);
    end
    chk("b2b_strobes", 64'(t.size()), 64'd2);
    if (t.size() == 2) chk("b2b_spacing", 64'(t[1] - t[0]), 64'd3);
    drain("back_to_back", 20);

    // Reset while in WRITE: outputs clear at once, write retried after release.
    #1;
    push_exp(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0);
    core_items.push_back('{16'h0010, 16'hBEEF});
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.sr_ie) seen = 1'b1;
    end
    chk("rst_write_seen", seen, 1'b1);
    if (seen) begin
      rst_n = 1'b0;
      #1;
      chk("rst_async_clear", {bus.core_ack, bus.dbg_ack, bus.sr_ie, bus.sr_sel, bus.sr_in,
                              bus.sr_err, bus.grant_dbg}, 64'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("reset_mid_write", 20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
